pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and forwarding controller for a 5-stage in-order pipeline.
//
// The block keeps shadow records of the EX, MEM and WB stages. From these it
// detects load-use hazards and taken branches, and drives the PC/IF-ID enables,
// the flush and bubble strobes, and the EX operand forwarding selects.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   id_valid                   ID stage holds a real instruction
//   id_rs, id_rt               ID source register numbers
//   id_uses_rs, id_uses_rt     ID instruction reads rs / rt
//   id_regwr, id_memtoreg      ID instruction writes the register file / is a load
//   id_rw                      ID destination register (after RegDst)
//   ex_taken                   branch in EX resolved taken this cycle
//   pc_en, ifid_en             PC and IF/ID write enables
//   ifid_flush, idex_bubble    zero IF/ID / insert a NOP into ID/EX at the next edge
//   fwd_a, fwd_b               EX operand source: 00 regfile, 01 MEM ALU out, 10 WB busW
//   ctrl_state                 action applied at the last edge: 00 RUN, 01 STALL, 10 FLUSH
//   stall_cnt, flush_cnt       saturating event counters
module pipeline_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_regwr,
  input  logic        id_memtoreg,
  input  logic [4:0]  id_rw,
  input  logic        ex_taken,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  ctrl_state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } action_e;

  typedef struct packed {
    logic       valid;
    logic       regwr;
    logic       memtoreg;
    logic [4:0] rw;
    logic [4:0] rs;
    logic [4:0] rt;
  } ex_rec_t;

  // Later stages only keep the fields the hazard/forwarding logic consults;
  // source registers are dead once an instruction leaves EX.
  typedef struct packed {
    logic       valid;
    logic       regwr;
    logic       memtoreg;
    logic [4:0] rw;
  } mem_rec_t;

  typedef struct packed {
    logic       valid;
    logic       regwr;
    logic [4:0] rw;
  } wb_rec_t;

  ex_rec_t  ex_q;
  mem_rec_t mem_q;
  wb_rec_t  wb_q;
  action_e  state_q;
  action_e  decision;
  logic     load_use;
  logic     do_flush;

  always_comb begin
    load_use = ex_q.valid && ex_q.memtoreg && (ex_q.rw != 5'd0) && id_valid &&
               ((id_uses_rs && (id_rs == ex_q.rw)) ||
                (id_uses_rt && (id_rt == ex_q.rw)));
    do_flush = ex_taken && ex_q.valid;
    if (do_flush)      decision = ST_FLUSH;
    else if (load_use) decision = ST_STALL;
    else               decision = ST_RUN;
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (decision)
        ST_FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        ST_STALL: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // MEM wins over WB as the youngest producer; a load in MEM has no ALU
  // result to forward, so it is excluded from the MEM path.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!reset && ex_q.valid) begin
      if (mem_q.valid && mem_q.regwr && !mem_q.memtoreg && (mem_q.rw != 5'd0) &&
          (mem_q.rw == ex_q.rs))
        fwd_a = 2'b01;
      else if (wb_q.valid && wb_q.regwr && (wb_q.rw != 5'd0) && (wb_q.rw == ex_q.rs))
        fwd_a = 2'b10;
      if (mem_q.valid && mem_q.regwr && !mem_q.memtoreg && (mem_q.rw != 5'd0) &&
          (mem_q.rw == ex_q.rt))
        fwd_b = 2'b01;
      else if (wb_q.valid && wb_q.regwr && (wb_q.rw != 5'd0) && (wb_q.rw == ex_q.rt))
        fwd_b = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      state_q   <= ST_RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      wb_q.valid     <= mem_q.valid;
      wb_q.regwr     <= mem_q.regwr;
      wb_q.rw        <= mem_q.rw;
      mem_q.valid    <= ex_q.valid;
      mem_q.regwr    <= ex_q.regwr;
      mem_q.memtoreg <= ex_q.memtoreg;
      mem_q.rw       <= ex_q.rw;
      ex_q.valid     <= (decision == ST_RUN) ? id_valid : 1'b0;
      ex_q.regwr     <= id_regwr;
      ex_q.memtoreg  <= id_memtoreg;
      ex_q.rw        <= id_rw;
      ex_q.rs        <= id_rs;
      ex_q.rt        <= id_rt;
      state_q        <= decision;
      if (decision == ST_STALL && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (decision == ST_FLUSH && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign ctrl_state = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_regwr;
  logic        id_memtoreg;
  logic [4:0]  id_rw;
  logic        ex_taken;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_bubble;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int unsigned total;
  int unsigned bad;

  pipeline_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_regwr    (id_regwr),
    .id_memtoreg (id_memtoreg),
    .id_rw       (id_rw),
    .ex_taken    (ex_taken),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .ctrl_state  (ctrl_state),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt,
                        input logic wr, input logic mtr, input logic [4:0] rw);
    id_valid    = v;
    id_rs       = rs;
    id_uses_rs  = urs;
    id_rt       = rt;
    id_uses_rt  = urt;
    id_regwr    = wr;
    id_memtoreg = mtr;
    id_rw       = rw;
  endtask

  task automatic id_idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_pc_en"},       {15'd0, pc_en},       16'd0);
    chk({pfx, "_ifid_en"},     {15'd0, ifid_en},     16'd0);
    chk({pfx, "_ifid_flush"},  {15'd0, ifid_flush},  16'd1);
    chk({pfx, "_idex_bubble"}, {15'd0, idex_bubble}, 16'd1);
    chk({pfx, "_fwd_a"},       {14'd0, fwd_a},       16'd0);
    chk({pfx, "_fwd_b"},       {14'd0, fwd_b},       16'd0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    ex_taken = 1'b0;
    id_idle();

    // ---------------- reset state
    tick();
    tick();
    chk_reset_outputs("rst");
    chk("rst_state", {14'd0, ctrl_state}, 16'd0);
    chk("rst_scnt", stall_cnt, 16'd0);
    chk("rst_fcnt", flush_cnt, 16'd0);

    // ---------------- load-use: lw r8, then consumer reading r8
    reset = 1'b0;
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8);  // lw r8
    #1;
    chk("lu_pre_pc_en", {15'd0, pc_en}, 16'd1);
    tick();
    set_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd10); // add r10, r8
    #1;
    chk("lu_pc_en", {15'd0, pc_en}, 16'd0);
    chk("lu_ifid_en", {15'd0, ifid_en}, 16'd0);
    chk("lu_bubble", {15'd0, idex_bubble}, 16'd1);
    chk("lu_flush", {15'd0, ifid_flush}, 16'd0);
    tick();
    #1;
    chk("lu_state", {14'd0, ctrl_state}, 16'd1);
    chk("lu_scnt", stall_cnt, 16'd1);
    chk("lu_no_2nd_stall", {15'd0, pc_en}, 16'd1);
    tick();
    id_idle();
    #1;
    chk("lu_fwd_a", {14'd0, fwd_a}, 16'd2);
    chk("lu_fwd_b", {14'd0, fwd_b}, 16'd0);
    chk("lu_state_run", {14'd0, ctrl_state}, 16'd0);

    // ---------------- double forward: sub r5 (WB), add r5 (MEM), consumer rs=rt=5
    tick();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd5);  // sub r5
    tick();
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 5'd5);  // add r5
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd6);  // consumer
    tick();
    id_idle();
    #1;
    chk("df_fwd_a", {14'd0, fwd_a}, 16'd1);
    chk("df_fwd_b", {14'd0, fwd_b}, 16'd1);
    tick();
    #1;
    chk("df_ex_empty_fwd_a", {14'd0, fwd_a}, 16'd0);

    // ---------------- WB-only forward: add r6, gap, consumer reads r6 in rt
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd6);
    tick();
    id_idle();
    tick();
    set_id(1'b1, 5'd9, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    id_idle();
    #1;
    chk("wb_fwd_a", {14'd0, fwd_a}, 16'd0);
    chk("wb_fwd_b", {14'd0, fwd_b}, 16'd2);
    tick();

    // ---------------- flush beats stall
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8);  // lw r8
    tick();
    set_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd11);
    ex_taken = 1'b1;
    #1;
    chk("fl_ifid_flush", {15'd0, ifid_flush}, 16'd1);
    chk("fl_pc_en", {15'd0, pc_en}, 16'd1);
    chk("fl_ifid_en", {15'd0, ifid_en}, 16'd1);
    chk("fl_bubble", {15'd0, idex_bubble}, 16'd1);
    tick();
    // Bubble now in EX: a stale taken flag must not flush again.
    id_idle();
    #1;
    chk("fl_state", {14'd0, ctrl_state}, 16'd2);
    chk("fl_fcnt", flush_cnt, 16'd1);
    chk("fl_scnt", stall_cnt, 16'd1);
    chk("fl_invalid_ex", {15'd0, ifid_flush}, 16'd0);
    ex_taken = 1'b0;
    tick();

    // ---------------- register 0 never stalls or forwards
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0);  // lw r0
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);  // reads r0, r0
    #1;
    chk("r0_pc_en", {15'd0, pc_en}, 16'd1);
    chk("r0_bubble", {15'd0, idex_bubble}, 16'd0);
    tick();
    #1;
    chk("r0_fwd_a_mem", {14'd0, fwd_a}, 16'd0);
    tick();
    #1;
    chk("r0_fwd_a_wb", {14'd0, fwd_a}, 16'd0);
    chk("r0_fwd_b_wb", {14'd0, fwd_b}, 16'd0);
    chk("r0_scnt", stall_cnt, 16'd1);
    id_idle();
    tick();

    // ---------------- stall counter saturation
    force dut.stall_cnt = 16'hFFFE;
    #1;
    release dut.stall_cnt;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8);
      tick();
      set_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      tick();
      #1;
      chk($sformatf("sat_state_%0d", i), {14'd0, ctrl_state}, 16'd1);
      chk($sformatf("sat_scnt_%0d", i), stall_cnt, 16'hFFFF);
    end
    id_idle();
    tick();

    // ---------------- reset during a stall
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8);
    tick();
    set_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    chk("rs_stall_pending", {15'd0, pc_en}, 16'd0);
    reset = 1'b1;
    #1;
    chk_reset_outputs("rs");
    tick();
    reset = 1'b0;
    #1;
    chk("rs_state", {14'd0, ctrl_state}, 16'd0);
    chk("rs_scnt", stall_cnt, 16'd0);
    chk("rs_fcnt", flush_cnt, 16'd0);
    chk("rs_no_stall", {15'd0, pc_en}, 16'd1);
    chk("rs_fwd_a", {14'd0, fwd_a}, 16'd0);
    tick();
    id_idle();
    #1;
    chk("rs_empty_fwd_a", {14'd0, fwd_a}, 16'd0);
    chk("rs_state_run", {14'd0, ctrl_state}, 16'd0);
    chk("rs_scnt2", stall_cnt, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
